// File: rtl/scan_pkg.sv
// Shared definitions for the pixel scan sequencer: field widths, parameter
// defaults and the sequencer state encoding.
package scan_pkg;

    localparam int ADC_W       = 12;
    localparam int X_W         = 5;
    localparam int Y_W         = 9;

    localparam int NX_DEF      = 32;
    localparam int NY_DEF      = 128;
    localparam int SETTLE_DEF  = 20;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_CONVERT   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_EMIT      = 3'd4,
        ST_ADVANCE   = 3'd5
    } state_t;

    // Bits needed to hold a down-count loaded with (max_val - 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with a zero flag; shared by the settle delay and the
// ADC completion timeout.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Raster scan sequencer: steps the deMUX address over an NX x NY frame, starts
// one ADC conversion per pixel and hands each result to the UART packer.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int NX          = NX_DEF,
    parameter int NY          = NY_DEF,
    parameter int SETTLE_CYC  = SETTLE_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [X_W-1:0]   deMUX_X,
    output logic [Y_W-1:0]   deMUX_Y,
    output logic             start_conv,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [ADC_W-1:0] sample_data,
    output logic             frame_start,
    output logic             frame_end,
    output logic             err_timeout
);

    localparam int MAX_LOAD = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TMR_W    = cnt_width(MAX_LOAD);

    // Both delays count down to zero inclusive, hence the minus one.
    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [ADC_W-1:0] r_sample_data;
    logic             r_err;

    state_t           w_state_nxt;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
    logic             w_capture;
    logic             w_timeout;
    logic             w_advance;
    logic             w_last_x;
    logic             w_last_y;
    logic             w_at_origin;

    assign w_last_x    = (r_x == X_W'(NX - 1));
    assign w_last_y    = (r_y == Y_W'(NY - 1));
    assign w_at_origin = (r_x == '0) && (r_y == '0);

    scan_timer #(
        .W          (TMR_W)
    ) u_timer (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_dec   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_at_origin) begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_CONVERT;
                end else begin
                    w_tmr_dec   = 1'b1;
                end
            end
            ST_CONVERT: begin
                w_state_nxt = ST_WAIT_DONE;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TIMEOUT_LD;
            end
            ST_WAIT_DONE: begin
                // A done pulse on the final timeout cycle still wins.
                if (adc_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_EMIT;
                end else if (w_tmr_zero) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_tmr_dec   = 1'b1;
                end
            end
            ST_EMIT: begin
                if (sample_ready) begin
                    w_state_nxt = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                w_advance = 1'b1;
                if (w_last_x && w_last_y && !enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = SETTLE_LD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_sample_data <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_sample_data <= adc_data;
            end
            if (w_timeout) begin
                r_sample_data <= '1;
                r_err         <= 1'b1;
            end
            if (w_advance) begin
                if (w_last_x) begin
                    r_x <= '0;
                    r_y <= w_last_y ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    assign deMUX_X      = r_x;
    assign deMUX_Y      = r_y;
    assign start_conv   = (r_state == ST_CONVERT);
    assign sample_valid = (r_state == ST_EMIT);
    assign sample_data  = r_sample_data;
    assign frame_start  = sample_valid && w_at_origin;
    assign frame_end    = sample_valid && w_last_x && w_last_y;
    assign err_timeout  = r_err;

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized bench for scan_sequencer on a 4x2 frame; expected timing and data
// come from pixel-level arithmetic kept in the bench.
module tb_scan_sequencer;
    import scan_pkg::*;

    localparam int NX   = 4;
    localparam int NY   = 2;
    localparam int S    = 3;
    localparam int T    = 5;
    localparam int NPIX = NX * NY;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;
    logic             sample_ready;
    logic [X_W-1:0]   deMUX_X;
    logic [Y_W-1:0]   deMUX_Y;
    logic             start_conv;
    logic             sample_valid;
    logic [ADC_W-1:0] sample_data;
    logic             frame_start;
    logic             frame_end;
    logic             err_timeout;

    int n_vec    = 0;
    int n_err    = 0;
    int pix      = 0;
    int next_gap = S + 1;
    bit err_model = 1'b0;

    scan_sequencer #(
        .NX          (NX),
        .NY          (NY),
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .deMUX_X      (deMUX_X),
        .deMUX_Y      (deMUX_Y),
        .start_conv   (start_conv),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .err_timeout  (err_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"},     32'(deMUX_X), 0);
        chk({tag, "_y"},     32'(deMUX_Y), 0);
        chk({tag, "_conv"},  32'(start_conv), 0);
        chk({tag, "_valid"}, 32'(sample_valid), 0);
        chk({tag, "_data"},  32'(sample_data), 0);
        chk({tag, "_fs"},    32'(frame_start), 0);
        chk({tag, "_fe"},    32'(frame_end), 0);
        chk({tag, "_err"},   32'(err_timeout), 0);
    endtask

    // Scanner should sit idle at the origin, ignoring stray done pulses.
    task automatic expect_idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            adc_done = ($urandom_range(0, 2) == 0);
            adc_data = 12'($urandom);
            step();
            chk("idle_conv", 32'(start_conv), 0);
            chk("idle_valid", 32'(sample_valid), 0);
        end
        adc_done = 1'b0;
        chk("idle_x", 32'(deMUX_X), 0);
        chk("idle_y", 32'(deMUX_Y), 0);
    endtask

    // One pixel: d = WAIT cycle carrying adc_done (d > T means never answered),
    // hold = cycles sample_ready stays low once the sample is offered.
    task automatic do_pixel(input int d, input int hold, input bit drop_en, input bit rst_in_wait);
        int n;
        int c;
        int lat_exp;
        bit got;
        int ex;
        int ey;
        logic [ADC_W-1:0] dat;
        logic [ADC_W-1:0] exp_data;
        ex = pix % NX;
        ey = pix / NX;
        n = 0;
        got = 1'b0;
        while (!got && n < next_gap + 8) begin
            step();
            n++;
            if (start_conv) begin
                got = 1'b1;
            end else begin
                chk("gap_valid", 32'(sample_valid), 0);
                adc_done = ($urandom_range(0, 3) == 0);
                adc_data = 12'($urandom);
            end
        end
        chk("conv_gap", n, next_gap);
        if (!got) return;
        chk("conv_x", 32'(deMUX_X), ex);
        chk("conv_y", 32'(deMUX_Y), ey);
        if (drop_en) enable = 1'b0;
        adc_done = ($urandom_range(0, 1) == 0);
        adc_data = 12'($urandom);
        if (rst_in_wait) begin
            adc_done = 1'b0;
            step();
            chk("wait_conv_low", 32'(start_conv), 0);
            reset  = 1'b1;
            enable = 1'b0;
            step();
            reset = 1'b0;
            chk_all_zero("rst_wait");
            err_model = 1'b0;
            pix = 0;
            return;
        end
        dat = 12'($urandom);
        c = 0;
        got = 1'b0;
        while (!got && c < T + 4) begin
            step();
            c++;
            if (sample_valid) begin
                got = 1'b1;
            end else begin
                chk("wait_conv_low", 32'(start_conv), 0);
                adc_done = (c == d);
                adc_data = (c == d) ? dat : 12'($urandom);
            end
        end
        adc_done = 1'b0;
        lat_exp = ((d <= T) ? d : T) + 1;
        chk("done_latency", c, lat_exp);
        if (!got) return;
        exp_data = (d <= T) ? dat : 12'hFFF;
        if (d > T) err_model = 1'b1;
        chk("emit_data", 32'(sample_data), 32'(exp_data));
        chk("emit_fs", 32'(frame_start), (pix == 0) ? 1 : 0);
        chk("emit_fe", 32'(frame_end), (pix == NPIX - 1) ? 1 : 0);
        chk("emit_err", 32'(err_timeout), 32'(err_model));
        chk("emit_x", 32'(deMUX_X), ex);
        chk("emit_y", 32'(deMUX_Y), ey);
        sample_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            adc_done = ($urandom_range(0, 2) == 0);
            adc_data = 12'($urandom);
            step();
            chk("hold_valid", 32'(sample_valid), 1);
            chk("hold_data", 32'(sample_data), 32'(exp_data));
            chk("hold_x", 32'(deMUX_X), ex);
            chk("hold_y", 32'(deMUX_Y), ey);
            chk("hold_conv", 32'(start_conv), 0);
            chk("hold_fs", 32'(frame_start), (pix == 0) ? 1 : 0);
            chk("hold_fe", 32'(frame_end), (pix == NPIX - 1) ? 1 : 0);
            if (i == hold - 1) sample_ready = 1'b1;
        end
        adc_done = 1'b0;
        pix = (pix + 1) % NPIX;
        next_gap = S + 2;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        adc_done     = 1'b0;
        adc_data     = '0;
        sample_ready = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        expect_idle(5);

        // Back-to-back frame, done two cycles after start, ready always high.
        enable = 1'b1;
        next_gap = S + 1;
        for (int p = 0; p < NPIX; p++) do_pixel(2, 0, 1'b0, 1'b0);

        // Back-pressure, including a ten-cycle stall on one pixel.
        for (int p = 0; p < NPIX; p++)
            do_pixel($urandom_range(1, T), (p == 3) ? 10 : $urandom_range(0, 2), 1'b0, 1'b0);

        // Unanswered conversion, then mixed answered and timed-out pixels.
        for (int p = 0; p < NPIX; p++)
            do_pixel((p == 0) ? 100 : $urandom_range(1, T + 2), $urandom_range(0, 3), 1'b0, 1'b0);
        for (int p = 0; p < 2 * NPIX; p++)
            do_pixel($urandom_range(1, T + 2), $urandom_range(0, 3), 1'b0, 1'b0);

        // Enable released at (2,0): the frame runs to (3,1) and the scanner parks.
        for (int p = 0; p < NPIX; p++)
            do_pixel($urandom_range(1, T), $urandom_range(0, 2), (p == 2), 1'b0);
        expect_idle(S + 10);

        // Reset while waiting on the ADC at (1,1).
        enable = 1'b1;
        next_gap = S + 1;
        for (int p = 0; p < 5; p++) do_pixel($urandom_range(1, T), 0, 1'b0, 1'b0);
        do_pixel(1, 0, 1'b0, 1'b1);
        expect_idle(15);

        // Scanning restarts cleanly from the origin after reset.
        enable = 1'b1;
        next_gap = S + 1;
        for (int p = 0; p < NPIX; p++)
            do_pixel($urandom_range(1, T), $urandom_range(0, 2), (p == 0), 1'b0);
        expect_idle(S + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
